// File: rtl/ebike_pkg.sv
// rtl/ebike_pkg.sv - shared e-bike drive constants and cadence types
package ebike_pkg;

    localparam int CADENCE_W = 5;

    typedef logic [CADENCE_W-1:0] cadence_t;

    localparam cadence_t CADENCE_MAX = 5'd31;
    // Same threshold the desired-drive stage uses (cadence > 1 means pedaling)
    localparam cadence_t PEDAL_MIN   = 5'd2;

    function automatic cadence_t cadence_sat_inc(cadence_t v);
        return (v == CADENCE_MAX) ? v : v + cadence_t'(1);
    endfunction

endpackage

// File: rtl/cadence_debounce.sv
// rtl/cadence_debounce.sv - crank sensor synchroniser, debounce filter and rise detect
module cadence_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic filt_out,
    output logic rise
);

    localparam int              CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_accept;

    assign w_diff   = r_sync2 ^ r_filt;
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
            // Rise is registered alongside the filtered level so it is one cycle wide
            r_rise  <= w_accept & r_sync2;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt  <= '0;
                r_filt <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign filt_out = r_filt;
    assign rise     = r_rise;

endmodule

// File: rtl/cadence_meas.sv
// rtl/cadence_meas.sv - windowed crank edge count with saturated cadence and not-pedaling detect
module cadence_meas
    import ebike_pkg::*;
#(
    parameter int WIN_W    = 22,
    parameter int DEB_CYC  = 16,
    parameter int IDLE_WIN = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cadence_raw,
    output logic [CADENCE_W-1:0] cadence,
    output logic                 cadence_vld,
    output logic                 not_pedaling
);

    localparam int               IDLE_W    = $clog2(IDLE_WIN + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_WIN);

    logic [WIN_W-1:0]  r_win;
    cadence_t          r_edges;
    logic [IDLE_W-1:0] r_idle;
    logic              w_filt;
    logic              w_rise;
    logic              w_count;
    logic              w_win_end;
    cadence_t          w_closing;
    logic [IDLE_W-1:0] w_idle_nxt;

    cadence_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_in   (cadence_raw),
        .filt_out (w_filt),
        .rise     (w_rise)
    );

    assign w_count    = w_rise & w_filt;
    assign w_win_end  = &r_win;
    // Includes a rise on the window-end cycle so it lands in the closing window
    assign w_closing  = w_count ? cadence_sat_inc(r_edges) : r_edges;
    assign w_idle_nxt = (r_idle == IDLE_LAST) ? r_idle : r_idle + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win        <= '0;
            r_edges      <= '0;
            r_idle       <= '0;
            cadence      <= '0;
            cadence_vld  <= 1'b0;
            not_pedaling <= 1'b1;
        end else begin
            r_win       <= r_win + 1'b1;
            cadence_vld <= w_win_end;
            if (w_win_end) begin
                cadence <= w_closing;
                r_edges <= '0;
                if (w_closing >= PEDAL_MIN) begin
                    r_idle       <= '0;
                    not_pedaling <= 1'b0;
                end else begin
                    r_idle <= w_idle_nxt;
                    if (w_idle_nxt == IDLE_LAST) begin
                        not_pedaling <= 1'b1;
                    end
                end
            end else begin
                r_edges <= w_closing;
            end
        end
    end

endmodule
